// File: rtl/branch_predictor_pkg.sv
// -----------------------------------------------------------------------------
// branch_predictor_pkg
//   Shared configuration for the dynamic branch predictor: default PC width,
//   table depth, direction-counter width and the logical layout of one branch
//   target buffer entry.
// -----------------------------------------------------------------------------
package branch_predictor_pkg;

    localparam int BP_DATA_WIDTH = 32;
    localparam int BP_ENTRIES    = 64;
    localparam int BP_CNT_WIDTH  = 2;

    localparam int BP_IDX_W = $clog2(BP_ENTRIES);
    localparam int BP_TAG_W = BP_DATA_WIDTH - BP_IDX_W - 2;

    // One BTB entry at the default configuration.
    typedef struct packed {
        logic                     valid;
        logic [BP_TAG_W-1:0]      tag;
        logic [BP_DATA_WIDTH-1:0] target;
        logic [BP_CNT_WIDTH-1:0]  cnt;
    } bp_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// -----------------------------------------------------------------------------
// branch_predictor_sat_counter
//   Combinational next-value logic for a CNT_WIDTH-bit saturating up/down
//   direction counter.
//   Ports:
//     cnt_i        current counter value
//     up_i         1 = count up (taken), 0 = count down (not taken)
//     force_max_i  force the result to the maximum (unconditional jumps)
//     cnt_o        next counter value
// -----------------------------------------------------------------------------
module branch_predictor_sat_counter
    import branch_predictor_pkg::*;
#(
    parameter int CNT_WIDTH = BP_CNT_WIDTH
) (
    input  logic [CNT_WIDTH-1:0] cnt_i,
    input  logic                 up_i,
    input  logic                 force_max_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_MIN = '0;

    always_comb begin
        cnt_o = cnt_i;
        if (force_max_i) begin
            cnt_o = CNT_MAX;
        end else if (up_i) begin
            if (cnt_i != CNT_MAX) cnt_o = cnt_i + CNT_WIDTH'(1);
        end else begin
            if (cnt_i != CNT_MIN) cnt_o = cnt_i - CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped branch target buffer with per-entry saturating direction
//   counters. Fetch looks up pred_pc_i combinationally; execute trains the
//   table with resolved outcomes. Also flags mispredictions and keeps
//   branch / mispredict statistics.
//   Ports:
//     clk_i, rst_ni                  clock, asynchronous active-low reset
//     pred_pc_i                      fetch PC to predict
//     pred_hit_o/taken_o/target_o    prediction (target = PC+4 unless taken)
//     upd_valid_i                    a control-flow instruction resolved
//     upd_pc_i, upd_target_i         its PC and actual target
//     upd_uncond_i, upd_taken_i      JAL/JALR flag, actual outcome
//     upd_pred_taken_i/target_i      prediction made for it at fetch
//     flush_i                        invalidate every entry
//     mispredict_o                   combinational mispredict flag
//     branch_cnt_o, mispred_cnt_o    wrapping statistics counters
// -----------------------------------------------------------------------------
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int DATA_WIDTH = BP_DATA_WIDTH,
    parameter int ENTRIES    = BP_ENTRIES,
    parameter int CNT_WIDTH  = BP_CNT_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic [DATA_WIDTH-1:0] pred_pc_i,
    output logic                  pred_hit_o,
    output logic                  pred_taken_o,
    output logic [DATA_WIDTH-1:0] pred_target_o,

    input  logic                  upd_valid_i,
    input  logic [DATA_WIDTH-1:0] upd_pc_i,
    input  logic                  upd_uncond_i,
    input  logic                  upd_taken_i,
    input  logic [DATA_WIDTH-1:0] upd_target_i,
    input  logic                  upd_pred_taken_i,
    input  logic [DATA_WIDTH-1:0] upd_pred_target_i,

    input  logic                  flush_i,
    output logic                  mispredict_o,
    output logic [31:0]           branch_cnt_o,
    output logic [31:0]           mispred_cnt_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

    localparam logic [CNT_WIDTH-1:0] CNT_WEAK_T  = CNT_WIDTH'(1 << (CNT_WIDTH - 1));
    localparam logic [CNT_WIDTH-1:0] CNT_WEAK_NT = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

    // Table state: valid and counters are reset flops, tag/target are plain
    // storage so they can map to distributed RAM.
    logic [ENTRIES-1:0]    valid_q;
    logic [CNT_WIDTH-1:0]  cnt_q [ENTRIES];
    logic [TAG_W-1:0]      tag_q [ENTRIES];
    logic [DATA_WIDTH-1:0] tgt_q [ENTRIES];

    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    // PC bits [1:0] never carry index or tag information.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc_i[1:0], upd_pc_i[1:0]};

    // ---------------- lookup (reads pre-update contents) ----------------
    logic [IDX_W-1:0] pred_idx;
    logic [TAG_W-1:0] pred_tag;

    assign pred_idx      = pred_pc_i[IDX_W+1:2];
    assign pred_tag      = pred_pc_i[DATA_WIDTH-1:IDX_W+2];
    assign pred_hit_o    = valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);
    assign pred_taken_o  = pred_hit_o && cnt_q[pred_idx][CNT_WIDTH-1];
    assign pred_target_o = pred_taken_o ? tgt_q[pred_idx] : (pred_pc_i + DATA_WIDTH'(4));

    // ---------------- misprediction ----------------
    assign mispredict_o = upd_valid_i &&
                          ((upd_taken_i != upd_pred_taken_i) ||
                           (upd_taken_i && (upd_target_i != upd_pred_target_i)));

    // ---------------- update ----------------
    logic [IDX_W-1:0]     upd_idx;
    logic [TAG_W-1:0]     upd_tag;
    logic                 upd_hit;
    logic                 upd_eff_taken;
    logic                 upd_cnt_we;
    logic                 upd_tgt_we;
    logic [CNT_WIDTH-1:0] hit_cnt_nxt;
    logic [CNT_WIDTH-1:0] upd_cnt_nxt;

    assign upd_idx = upd_pc_i[IDX_W+1:2];
    assign upd_tag = upd_pc_i[DATA_WIDTH-1:IDX_W+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // A not-taken unconditional jump cannot happen; treat it as taken.
    assign upd_eff_taken = upd_taken_i | upd_uncond_i;

    // Flush suppresses any same-cycle training or allocation.
    assign upd_cnt_we = upd_valid_i && !flush_i && (upd_hit || upd_eff_taken);
    assign upd_tgt_we = upd_valid_i && !flush_i && upd_eff_taken;

    branch_predictor_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_sat_counter (
        .cnt_i       (cnt_q[upd_idx]),
        .up_i        (upd_eff_taken),
        .force_max_i (upd_uncond_i),
        .cnt_o       (hit_cnt_nxt)
    );

    // A fresh allocation starts weakly taken unless it is a jump.
    always_comb begin
        upd_cnt_nxt = hit_cnt_nxt;
        if (!upd_hit) upd_cnt_nxt = upd_uncond_i ? CNT_MAX : CNT_WEAK_T;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_WEAK_NT;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (upd_cnt_we) begin
            valid_q[upd_idx] <= 1'b1;
            cnt_q[upd_idx]   <= upd_cnt_nxt;
        end
    end

    // Gated by rst_ni so an update coinciding with reset leaves no partial
    // entry behind.
    always_ff @(posedge clk_i) begin
        if (rst_ni && upd_tgt_we) begin
            tag_q[upd_idx] <= upd_tag;
            tgt_q[upd_idx] <= upd_target_i;
        end
    end

    // ---------------- statistics ----------------
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_valid_i)  branch_cnt_d  = branch_cnt_q + 32'd1;
        if (mispredict_o) mispred_cnt_d = mispred_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] pred_pc_i;
    logic        pred_hit_o, pred_taken_o;
    logic [31:0] pred_target_o;
    logic        upd_valid_i, upd_uncond_i, upd_taken_i, upd_pred_taken_i;
    logic [31:0] upd_pc_i, upd_target_i, upd_pred_target_i;
    logic        flush_i, mispredict_o;
    logic [31:0] branch_cnt_o, mispred_cnt_o;

    int vectors = 0;
    int miscompares = 0;

    branch_predictor dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .pred_pc_i         (pred_pc_i),
        .pred_hit_o        (pred_hit_o),
        .pred_taken_o      (pred_taken_o),
        .pred_target_o     (pred_target_o),
        .upd_valid_i       (upd_valid_i),
        .upd_pc_i          (upd_pc_i),
        .upd_uncond_i      (upd_uncond_i),
        .upd_taken_i       (upd_taken_i),
        .upd_target_i      (upd_target_i),
        .upd_pred_taken_i  (upd_pred_taken_i),
        .upd_pred_target_i (upd_pred_target_i),
        .flush_i           (flush_i),
        .mispredict_o      (mispredict_o),
        .branch_cnt_o      (branch_cnt_o),
        .mispred_cnt_o     (mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: 64 entries, 2-bit counters (0..3), held as plain ints.
    bit          m_valid [64];
    int unsigned m_tag   [64];
    int unsigned m_tgt   [64];
    int          m_cnt   [64];
    int unsigned m_br, m_mis;

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 0;
            m_cnt[i]   = 1;
        end
        m_br  = 0;
        m_mis = 0;
    endfunction

    function automatic void model_pred(input int unsigned pc, output bit h,
                                       output bit t, output int unsigned tg);
        int i;
        i  = int'((pc / 4) % 64);
        h  = m_valid[i] && (m_tag[i] == pc / 256);
        t  = h && (m_cnt[i] >= 2);
        tg = t ? m_tgt[i] : pc + 4;
    endfunction

    function automatic void model_update(input bit v, input int unsigned pc, input bit unc,
                                         input bit tk, input int unsigned tgt, input bit fl);
        int  i;
        bit  h, t;
        i = int'((pc / 4) % 64);
        t = tk || unc;
        h = m_valid[i] && (m_tag[i] == pc / 256);
        if (fl) begin
            for (int k = 0; k < 64; k++) m_valid[k] = 0;
        end else if (v) begin
            if (h) begin
                if (unc)    m_cnt[i] = 3;
                else if (t) m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
                else        m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
                if (t) m_tgt[i] = tgt;
            end else if (t) begin
                m_valid[i] = 1;
                m_tag[i]   = pc / 256;
                m_tgt[i]   = tgt;
                m_cnt[i]   = unc ? 3 : 2;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive, check combinational outputs, clock, check counters.
    task automatic step(input logic [31:0] ppc, input logic v, input logic [31:0] upc,
                        input logic unc, input logic tk, input logic [31:0] tgt,
                        input logic ptk, input logic [31:0] ptgt, input logic fl);
        bit          eh, et, emis;
        int unsigned etg;
        pred_pc_i = ppc; upd_valid_i = v; upd_pc_i = upc; upd_uncond_i = unc;
        upd_taken_i = tk; upd_target_i = tgt; upd_pred_taken_i = ptk;
        upd_pred_target_i = ptgt; flush_i = fl;
        #1;
        model_pred(ppc, eh, et, etg);
        emis = v && ((tk != ptk) || (tk && (tgt != ptgt)));
        chk("pred_hit",    {31'b0, pred_hit_o},   {31'b0, eh});
        chk("pred_taken",  {31'b0, pred_taken_o}, {31'b0, et});
        chk("pred_target", pred_target_o,         etg);
        chk("mispredict",  {31'b0, mispredict_o}, {31'b0, emis});
        @(posedge clk_i);
        model_update(v, upc, unc, tk, tgt, fl);
        if (v)    m_br++;
        if (emis) m_mis++;
        #1;
        chk("branch_cnt",  branch_cnt_o,  m_br);
        chk("mispred_cnt", mispred_cnt_o, m_mis);
    endtask

    task automatic lookup(input logic [31:0] ppc);
        step(ppc, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit          h, t;
        int unsigned tg, pc;
        logic        v, unc, tk, ptk, fl;
        logic [31:0] tgt, ptgt;

        rst_ni = 1'b0;
        pred_pc_i = 32'h100; upd_valid_i = 0; upd_pc_i = 0; upd_uncond_i = 0;
        upd_taken_i = 0; upd_target_i = 0; upd_pred_taken_i = 0;
        upd_pred_target_i = 0; flush_i = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_hit",     {31'b0, pred_hit_o},   32'd0);
        chk("rst_taken",   {31'b0, pred_taken_o}, 32'd0);
        chk("rst_target",  pred_target_o,         32'h104);
        chk("rst_brcnt",   branch_cnt_o,          32'd0);
        chk("rst_miscnt",  mispred_cnt_o,         32'd0);
        rst_ni = 1'b1;

        // Allocate 0x100 -> 0x80, predicted not-taken: mispredict.
        step(32'h100, 1, 32'h100, 0, 1, 32'h80, 0, 32'h104, 0);
        lookup(32'h100);
        chk("alloc_target", pred_target_o, 32'h80);
        // Three not-taken updates: taken drops after the first, cnt floors.
        step(32'h100, 1, 32'h100, 0, 0, 32'h104, 1, 32'h80, 0);
        chk("nt1_taken", {31'b0, pred_taken_o}, 32'd0);
        step(32'h100, 1, 32'h100, 0, 0, 32'h104, 0, 32'h104, 0);
        step(32'h100, 1, 32'h100, 0, 0, 32'h104, 0, 32'h104, 0);
        lookup(32'h100);
        chk("nt3_hit", {31'b0, pred_hit_o}, 32'd1);
        // Aliasing: 0x200 shares the index with 0x100.
        step(32'h100, 1, 32'h200, 0, 1, 32'h900, 0, 32'h204, 0);
        lookup(32'h100);
        chk("alias_old_miss", {31'b0, pred_hit_o}, 32'd0);
        lookup(32'h200);
        chk("alias_new_target", pred_target_o, 32'h900);
        // Flush with a same-cycle taken update: nothing allocated.
        step(32'h300, 1, 32'h300, 0, 1, 32'h40, 0, 32'h304, 1);
        lookup(32'h300);
        chk("flush_miss", {31'b0, pred_hit_o}, 32'd0);
        lookup(32'h200);
        // JAL: same-cycle lookup misses, next cycle hits with strong counter.
        step(32'h400, 1, 32'h400, 1, 1, 32'h1000, 0, 32'h404, 0);
        lookup(32'h400);
        chk("jal_target", pred_target_o, 32'h1000);
        step(32'h400, 1, 32'h400, 0, 0, 32'h404, 1, 32'h1000, 0);
        chk("jal_strong", {31'b0, pred_taken_o}, 32'd1);
        // Illegal not-taken jump counts as taken.
        step(32'h500, 1, 32'h500, 1, 0, 32'h2000, 0, 32'h504, 0);
        lookup(32'h500);

        // Randomised traffic over a few indices with several aliasing tags.
        for (int n = 0; n < 400; n++) begin
            pc   = ($urandom_range(0, 3) << 8) | ($urandom_range(4, 6) << 2);
            v    = ($urandom_range(0, 3) != 0);
            unc  = ($urandom_range(0, 9) == 0);
            tk   = 1'($urandom_range(0, 1));
            tgt  = $urandom & 32'hFFFF_FFFC;
            fl   = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 1) == 1) begin
                model_pred(pc, h, t, tg);
                ptk  = t;
                ptgt = tg;
            end else begin
                ptk  = 1'($urandom_range(0, 1));
                ptgt = ($urandom_range(0, 1) == 1) ? tgt : pc + 4;
            end
            step(($urandom_range(0, 3) << 8) | ($urandom_range(4, 6) << 2),
                 v, pc, unc, tk, tgt, ptk, ptgt, fl);
        end

        // Reset landing on an update: the update is lost entirely.
        pred_pc_i = 32'h600; upd_valid_i = 1; upd_pc_i = 32'h600; upd_uncond_i = 0;
        upd_taken_i = 1; upd_target_i = 32'h3000; upd_pred_taken_i = 0;
        upd_pred_target_i = 32'h604; flush_i = 0;
        #1;
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        model_reset();
        lookup(32'h600);
        lookup(32'h400);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
